// File: rtl/panel_switches_pkg.sv
// Shared definitions for the front-panel switch reader: console command codes
// and the command handshake state encoding.
package panel_switches_pkg;

  localparam logic [1:0] CMD_NONE      = 2'b00;
  localparam logic [1:0] CMD_LOAD_ADDR = 2'b01;
  localparam logic [1:0] CMD_DEPOSIT   = 2'b10;
  localparam logic [1:0] CMD_START     = 2'b11;

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_PEND = 1'b1
  } hs_state_e;

  // Maps the command-button presses {press[3], press[2]} to a console command.
  function automatic logic [1:0] cmd_code(input logic [1:0] cmd_press);
    logic [1:0] code;
    code = CMD_NONE;
    case (cmd_press)
      2'b01:   code = CMD_LOAD_ADDR;
      2'b10:   code = CMD_DEPOSIT;
      2'b11:   code = CMD_START;
      default: code = CMD_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/panel_switches_debounce_bit.sv
// Single-bit debouncer: accepts a new level after STABLE consecutive
// differing samples taken on the shared sample tick.
module debounce_bit
  import panel_switches_pkg::*;
#(
  parameter int unsigned STABLE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic din,
  output logic dout
);

  localparam logic [3:0] STABLE_C = 4'(STABLE);

  logic [3:0] cnt_q, cnt_d;
  logic       lvl_q, lvl_d;

  // A sample matching the current level clears the count, so any bounce
  // back restarts the qualification run.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (tick) begin
      if (din == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q + 4'd1 == STABLE_C) begin
        lvl_d = din;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  assign dout = lvl_q;

endmodule

// File: rtl/panel_switches.sv
// Front-panel input reader: synchronises and debounces switches and buttons,
// builds the 16-bit console switch register and issues console commands.
module panel_switches
  import panel_switches_pkg::*;
#(
  parameter int unsigned TICK_DIV = 2048,
  parameter int unsigned STABLE   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  sw,
  input  logic [3:0]  btn,
  output logic [15:0] swr,
  output logic        cmd_valid,
  output logic [1:0]  cmd,
  input  logic        cmd_ack,
  output logic        overrun
);

  localparam int unsigned TW = $clog2(TICK_DIV);

  logic [TW-1:0] tcnt_q;
  logic          tick;
  logic [11:0]   sync1_q, sync2_q, db;
  logic [3:0]    btn_db, btn_prev_q, press_q;
  logic [7:0]    sw_db;
  logic [15:0]   swr_q;
  logic [1:0]    cmd_q, req_code;
  logic          valid_q, overrun_q;
  hs_state_e     state_q;

  assign tick = (tcnt_q == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q <= '0;
    end else if (tick) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {btn, sw};
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 12; i++) begin : g_db
    debounce_bit #(.STABLE(STABLE)) u_db (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .din   (sync2_q[i]),
      .dout  (db[i])
    );
  end

  assign sw_db  = db[7:0];
  assign btn_db = db[11:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev_q <= '0;
      press_q    <= '0;
      swr_q      <= '0;
    end else begin
      btn_prev_q <= btn_db;
      press_q    <= btn_db & ~btn_prev_q;
      if (press_q[0]) swr_q[7:0]  <= sw_db;
      if (press_q[1]) swr_q[15:8] <= sw_db;
    end
  end

  assign req_code = cmd_code(press_q[3:2]);

  // A request arriving while PEND is always dropped, even when the ack lands
  // in the same cycle; the CPU sees the slot free only one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HS_IDLE;
      valid_q   <= 1'b0;
      cmd_q     <= CMD_NONE;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        HS_IDLE: begin
          if (req_code != CMD_NONE) begin
            state_q <= HS_PEND;
            valid_q <= 1'b1;
            cmd_q   <= req_code;
          end
        end
        HS_PEND: begin
          if (req_code != CMD_NONE) overrun_q <= 1'b1;
          if (cmd_ack) begin
            state_q <= HS_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= HS_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign swr       = swr_q;
  assign cmd_valid = valid_q;
  assign cmd       = cmd_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_panel_switches.sv
// Self-checking bench for panel_switches with TICK_DIV=4, STABLE=3.
module tb_panel_switches;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sw;
  logic [3:0]  btn;
  logic [15:0] swr;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        cmd_ack;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int rises    = 0;
  logic prev_v = 1'b0;
  logic [1:0] exp_q[$];

  panel_switches #(.TICK_DIV(4), .STABLE(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .btn       (btn),
    .swr       (swr),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ack   (cmd_ack),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_valid && !prev_v) rises++;
    prev_v = cmd_valid;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit seen, output int n);
    seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (cmd_valid) seen = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ack_once();
    cmd_ack = 1'b1;
    cycles(1);
    cmd_ack = 1'b0;
  endtask

  task automatic test_reset();
    bit hit;
    reset = 1'b1; btn = 4'hF; sw = 8'hA5; cmd_ack = 1'b0;
    cycles(6);
    @(negedge clk);
    checks++; if (swr !== 16'h0) begin failures++; $display("FAIL reset_swr got=%h exp=0000", swr); end
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", cmd_valid); end
    checks++; if (cmd !== 2'b00) begin failures++; $display("FAIL reset_cmd got=%b exp=00", cmd); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    @(posedge clk); #1;
    reset = 1'b0; btn = 4'h0;
    hit = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (cmd_valid) hit = 1'b1;
    end
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL reset_no_cmd got=%b exp=0", hit); end
    #1;
  endtask

  task automatic test_switch_register();
    int r0;
    r0 = rises;
    sw = 8'h3C; cycles(25);
    btn[0] = 1'b1; cycles(25);
    btn[0] = 1'b0; cycles(25);
    checks++; if (swr[7:0] !== 8'h3C) begin failures++; $display("FAIL swr_low got=%h exp=3c", swr[7:0]); end
    sw = 8'hC1; cycles(25);
    btn[1] = 1'b1; cycles(25);
    btn[1] = 1'b0; cycles(25);
    checks++; if (swr !== 16'hC13C) begin failures++; $display("FAIL swr_full got=%h exp=c13c", swr); end
    checks++; if (rises !== r0) begin failures++; $display("FAIL swr_no_cmd got=%0d exp=%0d", rises, r0); end
  endtask

  task automatic test_bounce();
    bit seen;
    int n, r0;
    logic [1:0] e;
    r0 = rises;
    for (int i = 0; i < 8; i++) begin
      btn[2] = ~btn[2];
      cycles(5);
    end
    btn[2] = 1'b1;
    exp_q.push_back(2'b01);
    wait_valid(40, seen, n);
    checks++; if (!seen || n > 20) begin failures++; $display("FAIL bounce_latency got=%0d seen=%b exp<=20", n, seen); end
    e = exp_q.pop_front();
    checks++; if (cmd !== e) begin failures++; $display("FAIL bounce_cmd got=%b exp=%b", cmd, e); end
    cycles(30);
    checks++; if (rises !== r0 + 1) begin failures++; $display("FAIL bounce_count got=%0d exp=%0d", rises - r0, 1); end
    ack_once();
    btn[2] = 1'b0; cycles(30);
  endtask

  task automatic test_handshake();
    bit seen, stable;
    int n;
    logic [1:0] e;
    btn[3] = 1'b1;
    exp_q.push_back(2'b10);
    wait_valid(40, seen, n);
    e = exp_q.pop_front();
    checks++; if (!seen || cmd !== e) begin failures++; $display("FAIL hs_cmd got=%b seen=%b exp=%b", cmd, seen, e); end
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 20) btn[3] = 1'b0;
      @(negedge clk);
      if (cmd !== 2'b10 || cmd_valid !== 1'b1) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL hs_stable got=%b exp=1", stable); end
    @(posedge clk); #1;
    ack_once();
    @(negedge clk);
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL hs_ack_drop got=%b exp=0", cmd_valid); end
    cycles(20);
  endtask

  task automatic test_simultaneous();
    bit seen;
    int n, r0;
    logic [1:0] e;
    r0 = rises;
    btn[3:2] = 2'b11;
    exp_q.push_back(2'b11);
    wait_valid(40, seen, n);
    e = exp_q.pop_front();
    checks++; if (!seen || cmd !== e) begin failures++; $display("FAIL simul_cmd got=%b seen=%b exp=%b", cmd, seen, e); end
    cycles(20);
    checks++; if (rises !== r0 + 1) begin failures++; $display("FAIL simul_count got=%0d exp=1", rises - r0); end
    ack_once();
    btn[3:2] = 2'b00; cycles(30);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL simul_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_overrun();
    bit seen;
    int n;
    logic [1:0] e;
    btn[2] = 1'b1;
    exp_q.push_back(2'b01);
    wait_valid(40, seen, n);
    e = exp_q.pop_front();
    checks++; if (!seen || cmd !== e) begin failures++; $display("FAIL ovr_first got=%b seen=%b exp=%b", cmd, seen, e); end
    btn[2] = 1'b0; cycles(25);
    btn[3] = 1'b1; cycles(25);
    @(negedge clk);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    checks++; if (cmd !== 2'b01 || cmd_valid !== 1'b1) begin failures++; $display("FAIL ovr_keep got=%b/%b exp=01/1", cmd, cmd_valid); end
    @(posedge clk); #1;
    ack_once();
    btn[3] = 1'b0;
    @(negedge clk);
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL ovr_ack got=%b exp=0", cmd_valid); end
    cycles(30);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    reset = 1'b1; cycles(2); reset = 1'b0;
    @(negedge clk);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_reset got=%b exp=0", overrun); end
    #1;
  endtask

  initial begin
    test_reset();
    test_switch_register();
    test_bounce();
    test_handshake();
    test_simultaneous();
    test_overrun();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/panel_switches.md
# panel_switches

Front-panel input reader, the input-side counterpart of the LED/seven-segment PC display. Synchronises and debounces the board's 8 slide switches and 4 pushbuttons, assembles a 16-bit console switch register from two byte loads, and issues console commands to the CPU over a valid/ack handshake. It sits between the board I/O pins and the CPU console-command port.

## Interface
- `TICK_DIV`, 2048: clock cycles per debounce sample tick; must be ≥ 2.
- `STABLE`, 4: consecutive equal samples required to accept a new debounced level; range 2..15.
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `sw`  in  8: raw slide switches, asynchronous.
- `btn`  in  4: raw pushbuttons, asynchronous, 1 = pressed.
- `swr`  out  16: console switch register.
- `cmd_valid`  out  1: command pending.
- `cmd`  out  2: command code; 01 LOAD_ADDR, 10 DEPOSIT, 11 START; 00 is never presented while `cmd_valid`=1.
- `cmd_ack`  in  1: CPU accepts the pending command.
- `overrun`  out  1: sticky; a command was dropped.

## Operation
- All 12 raw inputs pass through a 2-flop synchroniser, then a per-bit debouncer.
- Tick counter runs 0..TICK_DIV-1 and wraps; `tick` is asserted for one cycle when the count equals TICK_DIV-1.
- Debouncer, per bit, on each tick:
  - If the sample equals the debounced level, clear the stable count.
  - Otherwise increment the stable count. When it reaches STABLE, load the new level and clear the count.
  - A bounce resets the count.
- A rising edge on debounced `btn[i]` produces a one-cycle `press[i]`.
- `press[0]`: `swr[7:0]` <= debounced `sw`. `press[1]`: `swr[15:8]` <= debounced `sw`. Both in the same cycle load both bytes.
- Command generation:
  - `press[2]` only -> LOAD_ADDR.
  - `press[3]` only -> DEPOSIT.
  - `press[2]` and `press[3]` in the same cycle -> START.
- Handshake, two states: IDLE and PEND.
  - IDLE + command: go to PEND, `cmd_valid`=1, `cmd` = code.
  - PEND + `cmd_ack`: go to IDLE; `cmd_valid` drops in the next cycle. The CPU must not assume a new command can be presented in the same cycle it acks.
  - PEND + new command without ack in that cycle: the new command is dropped and `overrun` is set. `cmd` and `cmd_valid` are unchanged.
  - PEND + new command + `cmd_ack` in the same cycle: the pending command completes, the new one is dropped, and `overrun` is set.
  - `cmd_ack` while IDLE: ignored.
- `overrun` clears only on `reset`.
- `cmd` is stable for the whole PEND interval.

## Timing
- Reset values:
  - `swr`=0, `cmd_valid`=0, `cmd`=00, `overrun`=0.
  - Synchronisers, debounced levels and stable counts = 0. Buttons are taken as released and switches as off.
  - Tick counter = 0.
- A switch held high through reset reaches its debounced level after STABLE ticks.
- Latency from a clean raw button edge to `cmd_valid`: 2 synchroniser cycles, plus STABLE ticks (up to STABLE×TICK_DIV cycles, depending on tick phase), plus 1 edge-detect cycle, plus 1 register cycle.
- `swr` updates in the cycle after `press`.
- Releasing a button produces no action.
- Reset asserted mid-debounce or during PEND: the pending command is discarded with no ack required, and all state returns to reset values on the next edge.

## Structure
- Shared package: command codes CMD_LOAD_ADDR=2'b01, CMD_DEPOSIT=2'b10, CMD_START=2'b11, and the handshake state encoding.
- Sub-module `debounce_bit` (params STABLE; ports `clk`, `reset`, `tick`, `din`, `dout`), instantiated 12 times.
- The tick counter is shared and lives in the top level.

## Test plan
All scenarios use TICK_DIV=4 and STABLE=3.

- **Reset:** hold `reset` with `btn`=4'hF and `sw`=8'hA5 -> all outputs 0. After release, no command issues until buttons are released and re-pressed.
- **Switch register:** `sw`=8'h3C, press `btn[0]` cleanly; then `sw`=8'hC1, press `btn[1]` -> `swr`=16'hC13C. `cmd_valid` stays 0 throughout.
- **Bounce rejection:** `btn[2]` toggles every 5 cycles for 40 cycles, then holds high -> exactly one LOAD_ADDR. `cmd_valid` rises within 2+12+4+2 cycles of the final edge.
- **Handshake:** DEPOSIT pending, `cmd_ack` withheld 100 cycles -> `cmd`=10 stable throughout. One-cycle ack -> `cmd_valid`=0 next cycle.
- **Simultaneous press:** `btn[3:2]` rise in the same cycle -> single START (`cmd`=11).
- **Overrun:** with LOAD_ADDR unacked, press `btn[3]` -> `overrun`=1 and `cmd` still 01. Ack -> IDLE, `overrun` stays 1 until `reset`.
